fwrisc_mds_seq: RTL

Multi-cycle sequencer for the fwrisc multiply/divide/shift (MDS) operation class. The exec stage issues one MDS operation (op code, two operands, destination register) over a valid/ready handshake. The block iterates it over a shared one-bit-per-cycle shift / shift-add / restoring-divide datapath and returns the 32-bit result with its destination tag. It replaces single-cycle barrel and multiplier logic with an area-lean sequenced unit.

---
 rtl/fwrisc_mds_pkg.sv | 53 +++++
 rtl/fwrisc_mds_step.sv | 54 +++++
 rtl/fwrisc_mds_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fwrisc_mds_pkg.sv
// Shared op encoding, sequencer states and op-class helpers for the
// fwrisc multiply/divide/shift unit.
package fwrisc_mds_pkg;

  localparam logic [3:0] OP_SLL    = 4'd0;
  localparam logic [3:0] OP_SRL    = 4'd1;
  localparam logic [3:0] OP_SRA    = 4'd2;
  localparam logic [3:0] OP_MUL    = 4'd3;
  localparam logic [3:0] OP_MULH   = 4'd4;
  localparam logic [3:0] OP_MULHSU = 4'd5;
  localparam logic [3:0] OP_MULHU  = 4'd6;
  localparam logic [3:0] OP_DIV    = 4'd7;
  localparam logic [3:0] OP_DIVU   = 4'd8;
  localparam logic [3:0] OP_REM    = 4'd9;
  localparam logic [3:0] OP_REMU   = 4'd10;
  localparam logic [3:0] OP_NUM_MDS = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mds_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op >= OP_MUL) && (op <= OP_MULHU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_rem(input logic [3:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // Operand A is treated as signed by MUL, MULH, MULHSU, DIV and REM
  function automatic logic a_signed(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Operand B is treated as signed by MUL, MULH, DIV and REM
  function automatic logic b_signed(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULH) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/fwrisc_mds_step.sv
// One iteration of the shared shift / shift-add / restoring-divide datapath.
// For multiply, lo holds the remaining multiplier bits and operand is the
// multiplicand; for divide, lo holds the remaining dividend bits, hi the
// partial remainder and operand the divisor. The quotient bit is returned
// separately; next_lo leaves a zero in its place.
module fwrisc_mds_step
  import fwrisc_mds_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  input  logic [31:0] operand,
  output logic [31:0] next_hi,
  output logic [31:0] next_lo,
  output logic        q_bit
);

  logic [32:0] sum;
  logic [32:0] trial;
  logic [32:0] diff;

  // Single-step next value for the selected op class
  always_comb begin
    next_hi = hi;
    next_lo = lo;
    q_bit   = 1'b0;
    sum     = '0;
    trial   = '0;
    diff    = '0;
    case (op)
      OP_SLL: next_lo = {lo[30:0], 1'b0};
      OP_SRL: next_lo = {1'b0, lo[31:1]};
      OP_SRA: next_lo = {lo[31], lo[31:1]};
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : 33'd0);
        next_hi = sum[32:1];
        next_lo = {sum[0], lo[31:1]};
      end
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
        trial   = {hi, lo[31]};
        diff    = trial - {1'b0, operand};
        next_lo = {lo[30:0], 1'b0};
        if (!diff[32]) begin
          q_bit   = 1'b1;
          next_hi = diff[31:0];
        end else begin
          next_hi = trial[31:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fwrisc_mds_seq.sv
// Multi-cycle MDS sequencer: accepts one op, iterates it through
// fwrisc_mds_step, applies sign correction and holds the result until taken.
module fwrisc_mds_seq
  import fwrisc_mds_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [5:0]      in_rd,
  input  logic            in_flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [5:0]      out_rd
);

  mds_state_e  state, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [31:0] data_d;
  logic [5:0]  rd_d;

  logic [31:0] step_hi, step_lo;
  logic        step_q;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  fwrisc_mds_step u_step (
    .op      (op_q),
    .hi      (hi_q),
    .lo      (lo_q),
    .operand (opnd_q),
    .next_hi (step_hi),
    .next_lo (step_lo),
    .q_bit   (step_q)
  );

  assign in_ready  = (state == ST_IDLE) && !reset;
  assign out_valid = (state == ST_DONE);

  // Operand magnitudes and sign-corrected final results
  always_comb begin
    a_neg    = a_signed(in_op) && in_a[31];
    b_neg    = b_signed(in_op) && in_b[31];
    a_mag    = a_neg ? (32'd0 - in_a) : in_a;
    b_mag    = b_neg ? (32'd0 - in_b) : in_b;
    prod_fix = neg_q ? (64'd0 - {hi_q, lo_q}) : {hi_q, lo_q};
    quot_fix = neg_q ? (32'd0 - lo_q) : lo_q;
    rem_fix  = neg_q ? (32'd0 - hi_q) : hi_q;
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    data_d  = out_data;
    rd_d    = out_rd;
    case (state)
      ST_IDLE: begin
        if (in_valid && !in_flush) begin
          op_d   = in_op;
          rd_d   = in_rd;
          hi_d   = 32'd0;
          lo_d   = in_a;
          opnd_d = in_b;
          neg_d  = 1'b0;
          cnt_d  = 6'd0;
          if (is_shift(in_op)) begin
            cnt_d = {1'b0, in_b[4:0]};
            if (in_b[4:0] == 5'd0) begin
              data_d  = in_a;
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end else if (is_mul(in_op)) begin
            lo_d    = b_mag;
            opnd_d  = a_mag;
            neg_d   = a_neg ^ b_neg;
            cnt_d   = 6'd32;
            state_d = ST_RUN;
          end else if (is_div(in_op) || is_rem(in_op)) begin
            if (in_b == 32'd0) begin
              data_d  = is_div(in_op) ? 32'hFFFF_FFFF : in_a;
              state_d = ST_DONE;
            end else begin
              lo_d    = a_mag;
              opnd_d  = b_mag;
              neg_d   = is_div(in_op) ? (a_neg ^ b_neg) : a_neg;
              cnt_d   = 6'd32;
              state_d = ST_RUN;
            end
          end else begin
            data_d  = 32'd0;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo | {31'd0, step_q};
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          if (is_shift(op_q)) begin
            data_d  = step_lo;
            state_d = ST_DONE;
          end else begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        if (op_q == OP_MUL) begin
          data_d = prod_fix[31:0];
        end else if (is_mul(op_q)) begin
          data_d = prod_fix[63:32];
        end else if (is_div(op_q)) begin
          data_d = quot_fix;
        end else begin
          data_d = rem_fix;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (in_flush) begin
      state_d = ST_IDLE;
      data_d  = out_data;
      rd_d    = out_rd;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      opnd_q   <= 32'd0;
      cnt_q    <= 6'd0;
      neg_q    <= 1'b0;
      out_data <= '0;
      out_rd   <= 6'd0;
    end else begin
      state    <= state_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      out_data <= data_d;
      out_rd   <= rd_d;
    end
  end

endmodule
